// File: rtl/seq_monitor.sv
// Lock/lap/error monitor for a free-running 0..MAX_VAL sequence counter.
// Optional sticky fault mode: define SEQ_MONITOR_STICKY_FAULT_EN.
module seq_monitor #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_VAL  = 12,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LAP_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_val,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_cnt,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [WIDTH-1:0] exp_val,
    output logic             fault
);

    localparam int unsigned      GoodW    = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] MaxCode  = WIDTH'(MAX_VAL);
    localparam logic [GoodW-1:0] LockCode = GoodW'(LOCK_CNT);

`ifdef SEQ_MONITOR_STICKY_FAULT_EN
    typedef enum logic [1:0] {StHunt, StVerify, StLocked, StFault} state_e;
`else
    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;
`endif

    state_e             state_q, state_d;
    logic [GoodW-1:0]   good_q, good_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;

    logic               valid;
    logic               match;
    logic [WIDTH-1:0]   nxt_val;

    // Written as if/else so an X/Z sample resolves to invalid in simulation.
    always_comb begin
        valid = 1'b0;
        match = 1'b0;
        if (in_val <= MaxCode) begin
            valid = 1'b1;
            if (in_val == exp_q) begin
                match = 1'b1;
            end
        end
        nxt_val = (in_val == MaxCode) ? '0 : in_val + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StHunt;
            good_q      <= '0;
            exp_q       <= '0;
            lap_q       <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            exp_q       <= exp_d;
            lap_q       <= lap_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (in_en) begin
            unique case (state_q)
                StHunt: begin
                    if (valid) begin
                        state_d = StVerify;
                        good_d  = GoodW'(1);
                    end
                end
                StVerify: begin
                    if (match) begin
                        good_d = good_q + GoodW'(1);
                        if (good_q + GoodW'(1) == LockCode) begin
                            state_d = StLocked;
                        end
                    end else begin
                        // The breaking sample is discarded, not used as a new seed.
                        state_d = StHunt;
                        good_d  = '0;
                    end
                end
                StLocked: begin
                    if (!match) begin
                        good_d = '0;
`ifdef SEQ_MONITOR_STICKY_FAULT_EN
                        state_d = StFault;
`else
                        state_d = StHunt;
`endif
                    end
                end
`ifdef SEQ_MONITOR_STICKY_FAULT_EN
                StFault: begin
                    state_d = StFault;
                end
`endif
                default: begin
                    state_d = StHunt;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        exp_d       = exp_q;
        lap_d       = lap_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        if (in_en) begin
            unique case (state_q)
                StHunt: begin
                    if (valid) begin
                        exp_d = nxt_val;
                    end
                end
                StVerify: begin
                    if (match) begin
                        exp_d = nxt_val;
                    end
                end
                StLocked: begin
                    if (match) begin
                        exp_d = nxt_val;
                        if (in_val == '0) begin
                            lap_d = lap_q + LAP_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        locked    = (state_q == StLocked);
        err_pulse = err_pulse_q;
        err_cnt   = err_cnt_q;
        lap_cnt   = lap_q;
        exp_val   = exp_q;
`ifdef SEQ_MONITOR_STICKY_FAULT_EN
        fault     = (state_q == StFault);
`else
        fault     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: driver pushes model predictions, monitor compares each cycle.
module tb_seq_monitor;

    localparam int MAXV = 12;
    localparam int LOCKN = 3;

    localparam int M_HUNT = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_en = 1'b0;
    logic [4:0] in_val = '0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] lap_cnt;
    logic [4:0] exp_val;
    logic       fault;

    seq_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_val    (in_val),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .lap_cnt   (lap_cnt),
        .exp_val   (exp_val),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];

    // Reference model: mode, run length of in-sequence samples, counters.
    int m_mode = M_HUNT;
    int m_run = 0;
    int m_exp = 0;
    int m_lap = 0;
    int m_err = 0;
    int m_pulse = 0;
    int sticky = 0;

    function automatic logic [23:0] pack_model();
        logic [23:0] r;
        r = {(m_mode == M_LOCKED) ? 1'b1 : 1'b0, m_pulse[0], 8'(m_err), 8'(m_lap),
             5'(m_exp), (m_mode == M_FAULT) ? 1'b1 : 1'b0};
        return r;
    endfunction

    function automatic void model_reset();
        m_mode = M_HUNT; m_run = 0; m_exp = 0; m_lap = 0; m_err = 0; m_pulse = 0;
    endfunction

    function automatic void model_step(input bit en, input int v);
        bit ok;
        int nx;
        m_pulse = 0;
        if (!en) return;
        ok = (v <= MAXV);
        nx = (v + 1) % (MAXV + 1);
        if (m_mode == M_HUNT) begin
            if (ok) begin m_exp = nx; m_run = 1; m_mode = M_VERIFY; end
        end else if (m_mode == M_VERIFY) begin
            if (ok && v == m_exp) begin
                m_exp = nx;
                m_run++;
                if (m_run == LOCKN) m_mode = M_LOCKED;
            end else begin
                m_mode = M_HUNT;
                m_run = 0;
            end
        end else if (m_mode == M_LOCKED) begin
            if (ok && v == m_exp) begin
                m_exp = nx;
                if (v == 0) m_lap = (m_lap + 1) % 256;
            end else begin
                m_pulse = 1;
                if (m_err < 255) m_err++;
                m_mode = sticky ? M_FAULT : M_HUNT;
                m_run = 0;
            end
        end
    endfunction

    task automatic step(input bit en, input int v);
        @(negedge clk);
        in_en = en;
        in_val = 5'(v);
        model_step(en, v);
        exp_q.push_back(pack_model());
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b0;
        in_en = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({locked, err_pulse, err_cnt, lap_cnt, exp_val, fault} != 24'h0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h expected 000000", name,
                     {locked, err_pulse, err_cnt, lap_cnt, exp_val, fault});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every edge presents registered outputs; compare to the oldest prediction.
    initial begin
        logic [23:0] want;
        logic [23:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got = {locked, err_pulse, err_cnt, lap_cnt, exp_val, fault};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got lk=%b ep=%b ec=%0d lap=%0d ev=%0d f=%b required lk=%b ep=%b ec=%0d lap=%0d ev=%0d f=%b",
                             $time, got[23], got[22], got[21:14], got[13:6], got[5:1], got[0],
                             want[23], want[22], want[21:14], want[13:6], want[5:1], want[0]);
                end
            end
        end
    end

    initial begin
        int sv;
`ifdef SEQ_MONITOR_STICKY_FAULT_EN
        sticky = 1;
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if ({locked, err_pulse, err_cnt, lap_cnt, exp_val, fault} != 24'h0) begin
            n_fail++;
            $display("FAIL power_on_reset: outputs=%h expected 000000",
                     {locked, err_pulse, err_cnt, lap_cnt, exp_val, fault});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic lock and first lap.
        for (int v = 0; v <= MAXV; v++) step(1, v);
        step(1, 0);
        step(1, 1);
        // Break while locked, then relock.
        for (int v = 2; v <= 6; v++) step(1, v);
        step(1, 8);
        step(1, 9); step(1, 10); step(1, 11);
        // Hold with in_en low, then resume with the expected code.
        step(1, 12); step(1, 0); step(1, 1); step(1, 2); step(1, 3);
        repeat (5) step(0, 9);
        step(1, 4);

        // Invalid codes never leave HUNT.
        do_reset("reset_before_invalid");
        step(1, 13); step(1, 31); step(1, 13);

        // Async reset mid-cycle while locked with three laps.
        do_reset("reset_before_laps");
        for (int i = 0; i < 40; i++) step(1, i % (MAXV + 1));
        @(negedge clk);
        exp_q.delete();
        do_reset("async_reset_locked");
        step(1, 7);

        // Lock, mismatch, then 20 correct samples (relocks, or stays faulted when sticky).
        do_reset("reset_before_fault");
        step(1, 0); step(1, 1); step(1, 2); step(1, 5);
        for (int i = 0; i < 20; i++) step(1, (6 + i) % (MAXV + 1));

        // Randomised traffic: mostly in-sequence with glitches and gaps.
        do_reset("reset_before_random");
        sv = 0;
        for (int i = 0; i < 1500; i++) begin
            bit en;
            int v;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 88) v = sv;
            else v = $urandom_range(0, 31);
            step(en, v);
            if (en) sv = (v <= MAXV) ? (v + 1) % (MAXV + 1) : sv;
        end

        // lap_cnt wraps modulo 256.
        do_reset("reset_before_lapwrap");
        for (int i = 0; i < 258 * (MAXV + 1) + 3; i++) step(1, i % (MAXV + 1));

        // err_cnt saturates at 255.
        do_reset("reset_before_errsat");
        for (int i = 0; i < 262; i++) begin
            step(1, 3); step(1, 4); step(1, 5); step(1, 9);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
